// File: rtl/bpsk_demodulator.sv
// BPSK demodulator: correlates each carrier period against a square reference,
// decides one bit per symbol and packs bits LSB-first into DATA_WIDTH-bit words.
module bpsk_demodulator #(
  parameter int unsigned SAMPLE_NUMBER = 256,
  parameter int unsigned SAMPLE_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH    = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           align,
  input  logic signed [SAMPLE_WIDTH-1:0] signal_in,
  output logic                           bit_out,
  output logic                           bit_valid,
  output logic        [DATA_WIDTH-1:0]   data_out,
  output logic                           data_valid
);

  localparam int unsigned CntW = $clog2(SAMPLE_NUMBER);
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  // One extra bit over log2(N)*max|sample| so +/-N*2^(W-1) never wraps.
  localparam int unsigned AccW = SAMPLE_WIDTH + CntW + 1;

  localparam logic [CntW-1:0] LastIdx = CntW'(SAMPLE_NUMBER - 1);
  localparam logic [CntW-1:0] HalfIdx = CntW'(SAMPLE_NUMBER / 2);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  logic        [CntW-1:0]       sample_cnt_q, sample_cnt_d;
  logic        [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic signed [AccW-1:0]       acc_q, acc_d;
  logic        [DATA_WIDTH-1:0] word_q, word_d;
  logic                         bit_out_q, bit_out_d;
  logic                         bit_valid_q, bit_valid_d;
  logic        [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                         data_valid_q, data_valid_d;

  logic signed [AccW-1:0]       sample_ext;
  logic signed [AccW-1:0]       contrib;
  logic signed [AccW-1:0]       acc_sum;
  logic                         decision;
  logic                         last_sample;
  logic                         last_bit;
  logic        [DATA_WIDTH-1:0] word_full;

  // Square-reference correlation term and bit decision for the current sample.
  always_comb begin
    sample_ext  = AccW'(signal_in);
    contrib     = (sample_cnt_q >= HalfIdx) ? -sample_ext : sample_ext;
    acc_sum     = acc_q + contrib;
    // Strictly positive decides 1; zero decides 0.
    decision    = !acc_sum[AccW-1] && (acc_sum != '0);
    last_sample = (sample_cnt_q == LastIdx);
    last_bit    = (bit_cnt_q == LastBit);
    word_full   = word_q;
    word_full[bit_cnt_q] = decision;
  end

  // Next-state: align wins over en and drops any coinciding completion.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    acc_d        = acc_q;
    word_d       = word_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    if (align) begin
      sample_cnt_d = '0;
      bit_cnt_d    = '0;
      acc_d        = '0;
      word_d       = '0;
    end else if (en) begin
      if (last_sample) begin
        sample_cnt_d = '0;
        acc_d        = '0;
        bit_out_d    = decision;
        bit_valid_d  = 1'b1;
        if (last_bit) begin
          bit_cnt_d    = '0;
          word_d       = '0;
          data_out_d   = word_full;
          data_valid_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
          word_d    = word_full;
        end
      end else begin
        sample_cnt_d = sample_cnt_q + CntW'(1);
        acc_d        = acc_sum;
      end
    end
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      acc_q        <= acc_d;
      word_q       <= word_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Self-checking bench for bpsk_demodulator with a sample-array reference model.
module tb_bpsk_demodulator;

  localparam int N    = 8;
  localparam int W    = 12;
  localparam int D    = 4;
  localparam int AccW = 16;

  logic                clk;
  logic                rst;
  logic                en;
  logic                align;
  logic signed [W-1:0] signal_in;
  logic                bit_out;
  logic                bit_valid;
  logic [D-1:0]        data_out;
  logic                data_valid;

  bpsk_demodulator #(
    .SAMPLE_NUMBER(N),
    .SAMPLE_WIDTH (W),
    .DATA_WIDTH   (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .align     (align),
    .signal_in (signal_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .data_out  (data_out),
    .data_valid(data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int S[N] = '{0, 1448, 2047, 1448, 0, -1448, -2047, -1448};

  // Reference model: raw samples of the current symbol plus collected bits.
  int           m_idx;
  int           m_sym[N];
  int           m_nbits;
  logic [D-1:0] m_word;
  logic         e_bit_out;
  logic         e_bit_valid;
  logic [D-1:0] e_data_out;
  logic         e_data_valid;

  int           n_bitv;
  int           n_datav;
  logic [31:0]  bit_hist;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Correlation of the first k stored samples against the square reference.
  function automatic int corr_of(input int k);
    int sum = 0;
    for (int i = 0; i < k; i++) begin
      if (i < N / 2) sum += m_sym[i];
      else           sum -= m_sym[i];
    end
    return sum;
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // One clock: drive at negedge, update model, check outputs at the next negedge.
  task automatic step(input logic e, input logic a, input int s);
    int                     corr;
    logic                   b;
    logic signed [AccW-1:0] part;
    en        = e;
    align     = a;
    signal_in = W'(s);
    e_bit_valid  = 1'b0;
    e_data_valid = 1'b0;
    if (a) begin
      m_idx   = 0;
      m_nbits = 0;
      m_word  = '0;
    end else if (e) begin
      if (m_idx == N - 1) begin
        part = AccW'(corr_of(N - 1));
        chk("acc_before_decision", 32'(dut.acc_q), 32'(part));
      end
      m_sym[m_idx] = s;
      m_idx++;
      if (m_idx == N) begin
        corr = corr_of(N);
        b    = (corr > 0);
        e_bit_out   = b;
        e_bit_valid = 1'b1;
        m_word[m_nbits] = b;
        m_nbits++;
        if (m_nbits == D) begin
          e_data_out   = m_word;
          e_data_valid = 1'b1;
          m_nbits      = 0;
          m_word       = '0;
        end
        m_idx = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("bit_valid", 32'(bit_valid), 32'(e_bit_valid));
    chk("data_valid", 32'(data_valid), 32'(e_data_valid));
    chk("bit_out", 32'(bit_out), 32'(e_bit_out));
    chk("data_out", 32'(data_out), 32'(e_data_out));
    if (bit_valid === 1'b1) begin
      n_bitv++;
      bit_hist = {bit_hist[30:0], bit_out};
    end
    if (data_valid === 1'b1) n_datav++;
  endtask

  // One symbol of +S (pos=1) or -S, with random idle gaps of 0..gap_max cycles.
  task automatic send_sym(input logic pos, input int gap_max);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gap_max)) step(1'b0, 1'b0, rand_sample());
      step(1'b1, 1'b0, pos ? S[i] : -S[i]);
    end
  endtask

  task automatic send_word(input logic [D-1:0] w, input int gap_max);
    for (int b = 0; b < D; b++) send_sym(w[b], gap_max);
  endtask

  // Pulse rst across one rising edge; outputs must clear without waiting for clk.
  task automatic do_reset();
    en    = 1'b0;
    align = 1'b0;
    rst   = 1'b1;
    #1;
    chk("rst_bit_out", 32'(bit_out), 32'd0);
    chk("rst_bit_valid", 32'(bit_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    m_idx        = 0;
    m_nbits      = 0;
    m_word       = '0;
    e_bit_out    = 1'b0;
    e_bit_valid  = 1'b0;
    e_data_out   = '0;
    e_data_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_acc", 32'(dut.acc_q), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [D-1:0] w;
    rst       = 1'b1;
    en        = 1'b0;
    align     = 1'b0;
    signal_in = '0;
    n_bitv    = 0;
    n_datav   = 0;
    bit_hist  = '0;
    @(negedge clk);
    do_reset();

    // S,-S,S,S with en held high.
    send_word(4'b1101, 0);
    chk("t1_bits", 32'(bit_hist[3:0]), 32'h0000_000B);
    chk("t1_data", 32'(data_out), 32'h0000_000D);

    // Same word with random idle gaps between samples.
    send_word(4'b1101, 5);
    chk("t2_bits", 32'(bit_hist[3:0]), 32'h0000_000B);
    chk("t2_data", 32'(data_out), 32'h0000_000D);

    // All-zero samples decide 0.
    for (int i = 0; i < 4 * N; i++) step(1'b1, 1'b0, 0);
    chk("t3_zero_bits", 32'(bit_hist[3:0]), 32'h0);
    chk("t3_zero_data", 32'(data_out), 32'h0);
    // Full-scale negative correlation.
    for (int i = 0; i < N; i++) step(1'b1, 1'b0, (i < N / 2) ? -2048 : 2047);
    chk("t3_fullscale_bit", 32'(bit_hist[0]), 32'h0);

    // Partial symbol, then align with en=1, then S,S,-S,-S.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, S[i]);
    step(1'b1, 1'b1, 1234);
    send_word(4'b0011, 0);
    chk("t4_data", 32'(data_out), 32'h3);

    // Two bits into a word, reset, then S,S,S,-S.
    send_sym(1'b1, 0);
    send_sym(1'b1, 0);
    do_reset();
    send_word(4'b0111, 0);
    chk("t5_data", 32'(data_out), 32'h7);

    // Three random words back to back.
    n_bitv  = 0;
    n_datav = 0;
    for (int k = 0; k < 3; k++) begin
      w = D'($urandom);
      send_word(w, 0);
      chk("t6_word", 32'(data_out), 32'(w));
    end
    chk("t6_bit_pulses", 32'(n_bitv), 32'd12);
    chk("t6_word_pulses", 32'(n_datav), 32'd3);

    // Random samples, random en, occasional align.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), rand_sample());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
